// File: rtl/inst_mem_resp.sv
// Instruction memory with a fixed-latency fetch response port and a preload write port.
// Latency: WAIT_CYCLES+1 cycles from the accepting edge to the edge that raises inst_valid.
// Backpressure: ready drops while wait cycles remain, and ce is ignored then. A completing
//               fetch may accept the next request on the same edge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ce, pc                   fetch request strobe and byte address
//   ready                    request can be accepted this cycle
//   inst, inst_valid         fetched word and its single-cycle qualifier
//   addr_err                 completed fetch was misaligned or out of range
//   load_we/addr/data        preload write port, unaffected by the FSM and by rst
module inst_mem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           pc,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  ready,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  addr_err
);

    localparam int        DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] mem [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  bad_addr;
    logic                  accept;
    logic                  complete;

    assign rd_idx   = addr_q[DEPTH_LOG2+1:2];
    // Misaligned, or any address bit above the memory's byte range set.
    assign bad_addr = (|addr_q[1:0]) || (|addr_q[31:DEPTH_LOG2+2]);

    always_comb begin
        ready        = (state_q == IDLE) || (cnt_q == 4'd0);
        accept       = ce && ready;
        complete     = (state_q == BUSY) && (cnt_q == 4'd0);

        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        addr_err_d   = 1'b0;

        if (complete) begin
            inst_valid_d = 1'b1;
            state_d      = IDLE;
            if (bad_addr) begin
                inst_d     = 32'h0000_0000;
                addr_err_d = 1'b1;
            end else begin
                // Read sees the array before any same-edge preload write lands.
                inst_d     = mem[rd_idx];
            end
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - 4'd1;
        end

        // Accepting on the completing edge overrides the return to IDLE.
        if (accept) begin
            addr_d  = pc;
            cnt_d   = WAIT_LD;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Storage is never reset; preloads are honoured even while rst is high.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
module tb_inst_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    // dut1: WAIT_CYCLES=1, dut0: WAIT_CYCLES=0; both share reset and preload port.
    logic        ce1, ce0;
    logic [31:0] pc1, pc0;
    logic        ready1, ready0;
    logic [31:0] inst1, inst0;
    logic        valid1, valid0;
    logic        err1, err0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce1), .pc(pc1),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .ready(ready1), .inst(inst1), .inst_valid(valid1), .addr_err(err1)
    );

    inst_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce0), .pc(pc0),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .ready(ready0), .inst(inst0), .inst_valid(valid0), .addr_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WAIT_CYCLES=1 fetch on dut1: accept, one wait cycle, complete.
    task automatic fetch1(input logic [31:0] addr);
        ce1 = 1'b1;
        pc1 = addr;
        tick();
        ce1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; ce1 = 1'b0; ce0 = 1'b0; pc1 = '0; pc0 = '0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        #1;

        // Preload while reset is held.
        load_we = 1'b1;
        load_addr = 10'd0; load_data = 32'h2008_0005; tick();
        load_addr = 10'd1; load_data = 32'h1234_5678; tick();
        load_addr = 10'd2; load_data = 32'hDEAD_BEEF; tick();
        load_addr = 10'd3; load_data = 32'h1111_1111; tick();
        load_we = 1'b0;
        rst = 1'b0;

        chk("rst_ready",  32'(ready1), 32'd1);
        chk("rst_inst",   inst1,       32'h0);
        chk("rst_valid",  32'(valid1), 32'd0);
        chk("rst_err",    32'(err1),   32'd0);

        // Basic fetch with one wait cycle; ce dropped while busy.
        ce1 = 1'b1; pc1 = 32'h0;
        tick();
        ce1 = 1'b0;
        chk("w1_ready_wait", 32'(ready1), 32'd0);
        chk("w1_valid_wait", 32'(valid1), 32'd0);
        tick();
        chk("w1_ready_cnt0", 32'(ready1), 32'd1);
        chk("w1_valid_cnt0", 32'(valid1), 32'd0);
        tick();
        chk("w1_valid",  32'(valid1), 32'd1);
        chk("w1_inst",   inst1,       32'h2008_0005);
        chk("w1_err",    32'(err1),   32'd0);
        tick();
        chk("w1_valid_drop", 32'(valid1), 32'd0);
        chk("w1_inst_hold",  inst1,       32'h2008_0005);

        // Misaligned address.
        fetch1(32'h0000_0006);
        chk("mis_valid", 32'(valid1), 32'd1);
        chk("mis_inst",  inst1,       32'h0);
        chk("mis_err",   32'(err1),   32'd1);
        tick();
        chk("mis_err_clr", 32'(err1), 32'd0);

        fetch1(32'h0000_0004);
        chk("w1_inst_w1", inst1, 32'h1234_5678);

        // Out of range for a 1K-word memory.
        fetch1(32'h0000_1000);
        chk("oor_inst", inst1,     32'h0);
        chk("oor_err",  32'(err1), 32'd1);

        // Reset while busy with one wait cycle left.
        fetch1(32'h0000_0004);
        ce1 = 1'b1; pc1 = 32'h8;
        tick();
        ce1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_valid", 32'(valid1), 32'd0);
        chk("rb_inst",  inst1,       32'h0);
        chk("rb_ready", 32'(ready1), 32'd1);
        tick();
        chk("rb_no_pulse1", 32'(valid1), 32'd0);
        tick();
        chk("rb_no_pulse2", 32'(valid1), 32'd0);
        fetch1(32'h0000_0008);
        chk("rb_refetch_valid", 32'(valid1), 32'd1);
        chk("rb_refetch_inst",  inst1,       32'hDEAD_BEEF);

        // Back-to-back at WAIT_CYCLES=0.
        ce0 = 1'b1; pc0 = 32'h0;
        tick();
        pc0 = 32'h4;
        tick();
        chk("b2b_v0", 32'(valid0), 32'd1);
        chk("b2b_i0", inst0,       32'h2008_0005);
        chk("b2b_r0", 32'(ready0), 32'd1);
        pc0 = 32'h8;
        tick();
        chk("b2b_v1", 32'(valid0), 32'd1);
        chk("b2b_i1", inst0,       32'h1234_5678);
        ce0 = 1'b0;
        tick();
        chk("b2b_v2", 32'(valid0), 32'd1);
        chk("b2b_i2", inst0,       32'hDEAD_BEEF);
        tick();
        chk("b2b_idle", 32'(valid0), 32'd0);

        // Preload write colliding with a completing read of the same word.
        ce1 = 1'b1; pc1 = 32'hC;
        tick();
        ce1 = 1'b0;
        tick();
        load_we = 1'b1; load_addr = 10'd3; load_data = 32'hAAAA_5555;
        tick();
        load_we = 1'b0;
        chk("col_valid", 32'(valid1), 32'd1);
        chk("col_old",   inst1,       32'h1111_1111);
        fetch1(32'h0000_000C);
        chk("col_new",   inst1,       32'hAAAA_5555);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
